// File: rtl/spin_pkg.sv
// spin_pkg: shared state encoding, LFSR constants and width helpers for the
// spin ring controller.
package spin_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SPIN  = 2'd1,
    BRAKE = 2'd2,
    DONE  = 2'd3
  } spin_state_e;

  localparam int         LFSR_W     = 8;
  localparam logic [7:0] LFSR_TAPS  = 8'hB8;
  localparam logic [7:0] LFSR_RESET = 8'h01;

  // Interval counter must hold the longest brake gap, BASE_DIV*(brake_cnt+1).
  function automatic int cnt_width(input int base_div, input int brake_min);
    return $clog2(base_div * (brake_min + 9) + 1);
  endfunction

  // brake_cnt ranges BRAKE_MIN .. BRAKE_MIN+7.
  function automatic int brake_width(input int brake_min);
    return $clog2(brake_min + 8);
  endfunction

  // Step index serves both the fast-step count and the brake index k.
  function automatic int step_width(input int fast_steps, input int brake_min);
    int mx;
    mx = (fast_steps > brake_min + 7) ? fast_steps : brake_min + 7;
    return $clog2(mx + 1);
  endfunction

endpackage

// File: rtl/spin_lfsr.sv
// spin_lfsr: 8-bit Galois LFSR, free-running, with a synchronous seed load.
// A zero seed is replaced by the reset value so the register never locks up.
// Only the low RND_W bits are exported; that is all the controller consumes.
module spin_lfsr
  import spin_pkg::*;
#(
  parameter int RND_W = 3
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load,
  input  logic [LFSR_W-1:0] i_seed,
  output logic [RND_W-1:0]  o_rnd
);

  logic [LFSR_W-1:0] r_lfsr;

  // Load takes priority over the shift; no advance in a load cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_lfsr <= LFSR_RESET;
    else if (i_load)
      r_lfsr <= (i_seed == '0) ? LFSR_RESET : i_seed;
    else
      r_lfsr <= {1'b0, r_lfsr[LFSR_W-1:1]} ^ (r_lfsr[0] ? LFSR_TAPS : '0);
  end

  assign o_rnd = r_lfsr[RND_W-1:0];

endmodule

// File: rtl/spin_controller.sv
// spin_controller: rotates a one-hot lit position around an N_POS ring at a
// constant rate, then decelerates for a pseudo-random number of steps and
// stops. Optional macro SPIN_SEED_EN adds seed/seed_load ports that load the
// LFSR for deterministic runs.
module spin_controller
  import spin_pkg::*;
#(
  parameter int N_POS      = 8,
  parameter int BASE_DIV   = 4,
  parameter int FAST_STEPS = 16,
  parameter int BRAKE_MIN  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
`ifdef SPIN_SEED_EN
  input  logic [LFSR_W-1:0]        seed,
  input  logic                     seed_load,
`endif
  output logic [N_POS-1:0]         pos_onehot,
  output logic [$clog2(N_POS)-1:0] result,
  output logic                     busy,
  output logic                     done
);

  localparam int RES_W  = $clog2(N_POS);
  localparam int CNT_W  = cnt_width(BASE_DIV, BRAKE_MIN);
  localparam int BRK_W  = brake_width(BRAKE_MIN);
  localparam int STEP_W = step_width(FAST_STEPS, BRAKE_MIN);

  spin_state_e       r_state, w_state_nxt;
  logic              r_start_q;
  logic [N_POS-1:0]  r_pos;
  logic [RES_W-1:0]  r_result;
  logic [CNT_W-1:0]  r_cnt;
  logic [BRK_W-1:0]  r_brake;
  logic [STEP_W-1:0] r_step;

  logic              w_edge, w_tick, w_last_fast, w_last_brake;
  logic [CNT_W-1:0]  w_cnt_inc, w_target;
  logic [2:0]        w_rnd;
  logic              w_seed_load;
  logic [LFSR_W-1:0] w_seed;

`ifdef SPIN_SEED_EN
  assign w_seed_load = seed_load;
  assign w_seed      = seed;
`else
  assign w_seed_load = 1'b0;
  assign w_seed      = '0;
`endif

  spin_lfsr #(.RND_W(3)) u_lfsr (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_load  (w_seed_load),
    .i_seed  (w_seed),
    .o_rnd   (w_rnd)
  );

  // The edge is used in the same cycle it appears; start_q is the previous level.
  assign w_edge    = start & ~r_start_q;
  assign w_cnt_inc = r_cnt + 1'b1;
  // SPIN uses a fixed interval; brake step k waits BASE_DIV*(k+1) cycles.
  assign w_target  = (r_state == BRAKE) ? CNT_W'(BASE_DIV) * (CNT_W'(r_step) + 1'b1)
                                        : CNT_W'(BASE_DIV);
  assign w_tick       = ((r_state == SPIN) || (r_state == BRAKE)) && (w_cnt_inc == w_target);
  assign w_last_fast  = (r_step == STEP_W'(FAST_STEPS - 1));
  assign w_last_brake = (r_step == STEP_W'(r_brake));

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and status decode; edges outside IDLE are simply not looked at.
  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      IDLE:  if (w_edge) w_state_nxt = SPIN;
      SPIN: begin
        busy = 1'b1;
        if (w_tick && w_last_fast) w_state_nxt = BRAKE;
      end
      BRAKE: begin
        busy = 1'b1;
        if (w_tick && w_last_brake) w_state_nxt = DONE;
      end
      DONE: begin
        done        = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Ring, result index, interval counter, step index and brake length.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_start_q <= 1'b0;
      r_pos     <= N_POS'(1);
      r_result  <= '0;
      r_cnt     <= '0;
      r_brake   <= '0;
      r_step    <= '0;
    end else begin
      r_start_q <= start;
      if ((r_state == IDLE) && w_edge) begin
        r_brake <= BRK_W'(BRAKE_MIN) + BRK_W'(w_rnd);
        r_cnt   <= '0;
        r_step  <= '0;
      end else if (busy) begin
        if (w_tick) begin
          r_cnt    <= '0;
          r_pos    <= {r_pos[N_POS-2:0], r_pos[N_POS-1]};
          // Result advances with the ring so it always names the lit bit.
          r_result <= (r_result == RES_W'(N_POS - 1)) ? '0 : r_result + 1'b1;
          // Leaving SPIN the index restarts as brake step k = 1.
          r_step   <= ((r_state == SPIN) && w_last_fast) ? STEP_W'(1) : r_step + 1'b1;
        end else begin
          r_cnt <= w_cnt_inc;
        end
      end
    end
  end

  assign pos_onehot = r_pos;
  assign result     = r_result;

endmodule
